axis_stream_controller: RTL and testbench

CSR-controlled gate and sequencer for the H2C->C2H AXI-Stream loopback path in the application shell. It starts and stops streaming on packet boundaries, can stop after a programmed packet count, and keeps beat and packet statistics. It sits between the host streaming interface and the CSR register interface, and replaces the direct wire-through inside the application.

---
 rtl/axis_stream_controller_pkg.sv | 28 ++
 rtl/axis_register_slice.sv | 39 +++
 rtl/axis_stream_controller.sv | 165 ++++++++++++++++
 tb/tb_axis_stream_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_controller_pkg.sv
// Shared types and constants for the AXI-Stream loopback gate/sequencer.
// Optional tkeep checking is enabled with the AXIS_TKEEP_CHECK_EN macro.
package axis_stream_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int COUNTER_WIDTH = 32;

  localparam int ADDR_CONTROL      = 0;
  localparam int ADDR_STATUS       = 1;
  localparam int ADDR_BEAT_COUNT   = 2;
  localparam int ADDR_PACKET_COUNT = 3;
  localparam int ADDR_MAX_PACKETS  = 4;
  localparam int ADDR_ERROR_COUNT  = 5;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  // True when k is non-zero and of the form 0..01..1 (contiguous from bit 0).
  function automatic logic is_low_mask(input logic [255:0] k);
    return (k != '0) && ((k & (k + 256'd1)) == '0);
  endfunction

endpackage

// File: rtl/axis_register_slice.sv
// One-stage AXI-Stream pipeline register; full throughput, outputs held while stalled.
// Handshake: a beat moves when valid && ready are both high on a rising clock edge.
module axis_register_slice #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    s_load,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DATA_WIDTH/8-1:0] m_keep,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready
);

  assign s_ready = !m_valid || m_ready;

  // s_load is only asserted by the parent while s_ready is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (s_load) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_keep  <= s_keep;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_stream_controller.sv
// CSR-controlled gate/sequencer for the H2C->C2H loopback stream with statistics.
// Define AXIS_TKEEP_CHECK_EN to add the tkeep checker and ERROR_COUNT register.
module axis_stream_controller
  import axis_stream_controller_pkg::*;
#(
  parameter int CSR_DATA_WIDTH    = 32,
  parameter int CSR_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH        = 64
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         CSR_FF_valid,
  input  logic                         CSR_FF_write_enable,
  input  logic [CSR_ADDRESS_WIDTH-1:0] CSR_FF_address,
  input  logic [CSR_DATA_WIDTH-1:0]    CSR_FF_write_data,
  output logic [CSR_DATA_WIDTH-1:0]    CSR_FF_read_data,
  input  logic [DATA_WIDTH-1:0]        AXIS_H2C_tdata,
  input  logic [DATA_WIDTH/8-1:0]      AXIS_H2C_tkeep,
  input  logic                         AXIS_H2C_tlast,
  input  logic                         AXIS_H2C_tvalid,
  output logic                         AXIS_H2C_tready,
  output logic [DATA_WIDTH-1:0]        AXIS_C2H_tdata,
  output logic [DATA_WIDTH/8-1:0]      AXIS_C2H_tkeep,
  output logic                         AXIS_C2H_tlast,
  output logic                         AXIS_C2H_tvalid,
  input  logic                         AXIS_C2H_tready,
  output logic [1:0]                   debug_state
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  state_t state;
  logic   enable;
  logic   in_packet;
  cnt_t   max_packets;
  cnt_t   pkt_track;
  cnt_t   beat_count;
  cnt_t   packet_count;

  logic csr_wr, csr_rd, ctrl_wr, maxp_wr, clear;
  logic gate_open, slice_ready;
  logic h2c_accept, tlast_accept, c2h_fire;
  logic limit_hit, enable_nxt, in_packet_nxt;
  logic [CSR_DATA_WIDTH-1:0] rd_value;

  assign csr_wr  = CSR_FF_valid && CSR_FF_write_enable;
  assign csr_rd  = CSR_FF_valid && !CSR_FF_write_enable;
  assign ctrl_wr = csr_wr && (CSR_FF_address == CSR_ADDRESS_WIDTH'(ADDR_CONTROL));
  assign maxp_wr = csr_wr && (CSR_FF_address == CSR_ADDRESS_WIDTH'(ADDR_MAX_PACKETS));
  assign clear   = ctrl_wr && CSR_FF_write_data[CTRL_CLEAR_BIT];

  assign gate_open       = (state == ST_RUN) || (state == ST_DRAIN);
  assign AXIS_H2C_tready = gate_open && slice_ready;
  assign h2c_accept      = AXIS_H2C_tvalid && AXIS_H2C_tready;
  assign tlast_accept    = h2c_accept && AXIS_H2C_tlast;
  assign c2h_fire        = AXIS_C2H_tvalid && AXIS_C2H_tready;
  assign debug_state     = state;

  assign limit_hit     = tlast_accept && (max_packets != '0) &&
                         ((pkt_track + cnt_t'(1)) == max_packets);
  assign in_packet_nxt = h2c_accept ? !AXIS_H2C_tlast : in_packet;

  // Hardware clear from the packet limit overrides a same-cycle CSR write.
  always_comb begin
    enable_nxt = enable;
    if (ctrl_wr) enable_nxt = CSR_FF_write_data[CTRL_ENABLE_BIT];
    if (limit_hit) enable_nxt = 1'b0;
  end

  axis_register_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
    .clock   (clock),
    .reset_n (reset_n),
    .s_load  (h2c_accept),
    .s_data  (AXIS_H2C_tdata),
    .s_keep  (AXIS_H2C_tkeep),
    .s_last  (AXIS_H2C_tlast),
    .s_ready (slice_ready),
    .m_data  (AXIS_C2H_tdata),
    .m_keep  (AXIS_C2H_tkeep),
    .m_last  (AXIS_C2H_tlast),
    .m_valid (AXIS_C2H_tvalid),
    .m_ready (AXIS_C2H_tready)
  );

  // The FSM looks at the post-write enable and the post-accept packet state, so a
  // disable landing on the tlast beat closes the packet instead of entering DRAIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      enable      <= 1'b0;
      in_packet   <= 1'b0;
      pkt_track   <= '0;
      max_packets <= '0;
    end else begin
      enable    <= enable_nxt;
      in_packet <= in_packet_nxt;
      if (maxp_wr) max_packets <= CSR_FF_write_data[COUNTER_WIDTH-1:0];
      if (tlast_accept) pkt_track <= pkt_track + cnt_t'(1);
      case (state)
        ST_IDLE: begin
          if (enable_nxt) begin
            state     <= ST_RUN;
            pkt_track <= '0;
          end
        end
        ST_RUN: begin
          if (limit_hit) state <= ST_IDLE;
          else if (!enable_nxt) state <= in_packet_nxt ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (tlast_accept) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_count   <= '0;
      packet_count <= '0;
    end else if (clear) begin
      beat_count   <= '0;
      packet_count <= '0;
    end else if (c2h_fire) begin
      beat_count <= beat_count + cnt_t'(1);
      if (AXIS_C2H_tlast) packet_count <= packet_count + cnt_t'(1);
    end
  end

`ifdef AXIS_TKEEP_CHECK_EN
  cnt_t error_count;
  logic keep_bad;

  assign keep_bad = AXIS_H2C_tlast ? !is_low_mask(256'(AXIS_H2C_tkeep))
                                   : (AXIS_H2C_tkeep != '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) error_count <= '0;
    else if (clear) error_count <= '0;
    else if (h2c_accept && keep_bad) error_count <= error_count + cnt_t'(1);
  end
`endif

  always_comb begin
    rd_value = '0;
    case (CSR_FF_address)
      CSR_ADDRESS_WIDTH'(ADDR_CONTROL):      rd_value = CSR_DATA_WIDTH'(enable);
      CSR_ADDRESS_WIDTH'(ADDR_STATUS):       rd_value = CSR_DATA_WIDTH'({AXIS_C2H_tvalid, state});
      CSR_ADDRESS_WIDTH'(ADDR_BEAT_COUNT):   rd_value = CSR_DATA_WIDTH'(beat_count);
      CSR_ADDRESS_WIDTH'(ADDR_PACKET_COUNT): rd_value = CSR_DATA_WIDTH'(packet_count);
      CSR_ADDRESS_WIDTH'(ADDR_MAX_PACKETS):  rd_value = CSR_DATA_WIDTH'(max_packets);
`ifdef AXIS_TKEEP_CHECK_EN
      CSR_ADDRESS_WIDTH'(ADDR_ERROR_COUNT):  rd_value = CSR_DATA_WIDTH'(error_count);
`endif
      default:                               rd_value = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) CSR_FF_read_data <= '0;
    else if (csr_rd) CSR_FF_read_data <= rd_value;
  end

endmodule

// File: tb/tb_axis_stream_controller.sv
// Directed bench for axis_stream_controller: stimulus pushes expected beats/reads into
// queues, a negedge monitor pops and compares whenever the DUT presents an output.
module tb_axis_stream_controller;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int AW = 8;
  localparam int CW = 32;
  localparam int IW = DW + KW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          csr_valid, csr_we;
  logic [AW-1:0] csr_addr;
  logic [CW-1:0] csr_wdata, csr_rdata;
  logic [DW-1:0] h2c_tdata, c2h_tdata;
  logic [KW-1:0] h2c_tkeep, c2h_tkeep;
  logic          h2c_tlast, h2c_tvalid, h2c_tready;
  logic          c2h_tlast, c2h_tvalid;
  wire           c2h_tready;
  logic [1:0]    dbg_state;

  logic rand_mode, rand_bit, tready_fixed, lat_chk, rd_d;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [IW-1:0] exp_q[$];
  int            lat_q[$];
  logic [CW-1:0] csr_exp_q[$];
  string         csr_name_q[$];

  assign c2h_tready = rand_mode ? rand_bit : tready_fixed;

  axis_stream_controller #(
    .CSR_DATA_WIDTH(CW), .CSR_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clock(clk), .reset_n(reset_n),
    .CSR_FF_valid(csr_valid), .CSR_FF_write_enable(csr_we),
    .CSR_FF_address(csr_addr), .CSR_FF_write_data(csr_wdata),
    .CSR_FF_read_data(csr_rdata),
    .AXIS_H2C_tdata(h2c_tdata), .AXIS_H2C_tkeep(h2c_tkeep),
    .AXIS_H2C_tlast(h2c_tlast), .AXIS_H2C_tvalid(h2c_tvalid),
    .AXIS_H2C_tready(h2c_tready),
    .AXIS_C2H_tdata(c2h_tdata), .AXIS_C2H_tkeep(c2h_tkeep),
    .AXIS_C2H_tlast(c2h_tlast), .AXIS_C2H_tvalid(c2h_tvalid),
    .AXIS_C2H_tready(c2h_tready),
    .debug_state(dbg_state)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_d <= csr_valid && !csr_we;

  initial forever begin
    @(posedge clk); #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          stalled;
    logic [IW-1:0] held, got, exp;
    int            lat;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        got = {c2h_tlast, c2h_tkeep, c2h_tdata};
        if (stalled) check("c2h_hold_stable", 128'(got), 128'(held));
        if (c2h_tvalid && c2h_tready) begin
          if (exp_q.size() == 0) begin
            check("c2h_unexpected_beat", 128'(got), 128'(0));
          end else begin
            exp = exp_q.pop_front();
            lat = lat_q.pop_front();
            check("c2h_beat", 128'(got), 128'(exp));
            if (lat >= 0) check("c2h_latency", 128'(cyc), 128'(lat + 1));
          end
        end
        stalled = c2h_tvalid && !c2h_tready;
        held = got;
        if (rd_d) begin
          if (csr_exp_q.size() == 0) check("csr_unexpected_read", 128'(csr_rdata), 128'(0));
          else check(csr_name_q.pop_front(), 128'(csr_rdata), 128'(csr_exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic csr_write(input int addr, input logic [CW-1:0] data);
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = AW'(addr); csr_wdata = data;
    @(posedge clk); #1;
    csr_valid = 1'b0; csr_we = 1'b0;
  endtask

  task automatic csr_read(input int addr, input logic [CW-1:0] exp, input string name);
    csr_exp_q.push_back(exp);
    csr_name_q.push_back(name);
    csr_valid = 1'b1; csr_we = 1'b0; csr_addr = AW'(addr);
    @(posedge clk); #1;
    csr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input int budget, output bit acc);
    h2c_tdata = d; h2c_tkeep = k; h2c_tlast = l; h2c_tvalid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (h2c_tready) begin
        exp_q.push_back({l, k, d});
        lat_q.push_back(lat_chk ? cyc : -1);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    h2c_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit acc;
    bit blocked;
    logic [CW-1:0] exp_err1, exp_err2;
    reset_n = 1'b0;
    csr_valid = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    h2c_tdata = 64'h1234; h2c_tkeep = '1; h2c_tlast = 1'b0; h2c_tvalid = 1'b1;
    rand_mode = 1'b0; tready_fixed = 1'b1; lat_chk = 1'b0;

    // Reset: tready stays low with tvalid high, all registers read 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tready_in_reset", 128'(h2c_tready), 128'(0));
    check("c2h_tvalid_in_reset", 128'(c2h_tvalid), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("tready_idle", 128'(h2c_tready), 128'(0));
    check("debug_state_reset", 128'(dbg_state), 128'(0));
    @(posedge clk); #1;
    h2c_tvalid = 1'b0;
    for (int a = 0; a <= 5; a++) csr_read(a, 32'h0, "reset_reg");

    // Three 4-beat packets with C2H always ready; 1-cycle latency checked.
    csr_write(0, 32'h1);
    csr_read(1, 32'h1, "status_run");
    lat_chk = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) begin
        send_beat(64'hA000_0000_0000_0000 | 64'(p * 256 + b), 8'hFF, (b == 3), 20, acc);
        check("t1_accept", 128'(acc), 128'(1));
      end
    lat_chk = 1'b0;
    wait_drain(50);
    csr_read(2, 32'd12, "beat_count_12");
    csr_read(3, 32'd3, "packet_count_3");

    // 100 beats with randomly stalling C2H.
    rand_mode = 1'b1;
    for (int p = 0; p < 10; p++)
      for (int b = 0; b < 10; b++) begin
        send_beat({$urandom, $urandom}, 8'hFF, (b == 9), 100, acc);
        check("t2_accept", 128'(acc), 128'(1));
      end
    rand_mode = 1'b0; tready_fixed = 1'b1;
    wait_drain(200);
    csr_read(2, 32'd112, "beat_count_112");
    csr_read(3, 32'd13, "packet_count_13");

    // Disable mid-packet: DRAIN, remaining beats pass, then IDLE and gate closed.
    send_beat(64'hD1, 8'hFF, 1'b0, 20, acc);
    send_beat(64'hD2, 8'hFF, 1'b0, 20, acc);
    csr_write(0, 32'h0);
    csr_read(1, 32'h2, "status_drain");
    check("debug_state_drain", 128'(dbg_state), 128'(2));
    send_beat(64'hD3, 8'hFF, 1'b0, 20, acc);
    check("drain_accept_3", 128'(acc), 128'(1));
    send_beat(64'hD4, 8'hFF, 1'b0, 20, acc);
    send_beat(64'hD5, 8'hFF, 1'b1, 20, acc);
    check("drain_accept_last", 128'(acc), 128'(1));
    idle(2);
    csr_read(1, 32'h0, "status_idle_after_drain");
    h2c_tdata = 64'hBAD; h2c_tkeep = 8'hFF; h2c_tlast = 1'b0; h2c_tvalid = 1'b1;
    blocked = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (h2c_tready) blocked = 1'b0;
    end
    @(posedge clk); #1;
    h2c_tvalid = 1'b0;
    check("next_packet_blocked", 128'(blocked), 128'(1));
    wait_drain(50);
    csr_read(2, 32'd117, "beat_count_117");
    csr_read(3, 32'd14, "packet_count_14");

    // Packet limit of 2 with 4 packets offered.
    csr_write(4, 32'd2);
    csr_write(0, 32'h1);
    for (int p = 0; p < 4; p++) begin
      if (p < 2) begin
        for (int b = 0; b < 3; b++) begin
          send_beat(64'hC000 | 64'(p * 16 + b), 8'hFF, (b == 2), 20, acc);
          check("limit_accept", 128'(acc), 128'(1));
        end
      end else begin
        send_beat(64'hCF00 | 64'(p), 8'hFF, 1'b0, 8, acc);
        check("limit_block", 128'(acc), 128'(0));
      end
    end
    wait_drain(50);
    csr_read(0, 32'h0, "control_enable_cleared");
    csr_read(1, 32'h0, "status_idle_after_limit");
    csr_read(3, 32'd16, "packet_count_16");
    csr_read(2, 32'd123, "beat_count_123");
    csr_read(4, 32'd2, "max_packets_readback");

    // CLEAR in the same cycle as a C2H handshake.
    csr_write(4, 32'd0);
    csr_write(0, 32'h1);
    tready_fixed = 1'b0;
    send_beat(64'hE1, 8'hFF, 1'b1, 20, acc);
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 8'h00; csr_wdata = 32'h3;
    tready_fixed = 1'b1;
    @(posedge clk); #1;
    csr_valid = 1'b0; csr_we = 1'b0;
    idle(1);
    csr_read(2, 32'd0, "beat_count_clear_wins");
    csr_read(3, 32'd0, "packet_count_clear_wins");
    csr_read(0, 32'h1, "control_after_clear");

    // tkeep checking.
`ifdef AXIS_TKEEP_CHECK_EN
    exp_err1 = 32'd1; exp_err2 = 32'd2;
`else
    exp_err1 = 32'd0; exp_err2 = 32'd0;
`endif
    send_beat(64'hF1, 8'h0F, 1'b0, 20, acc);
    send_beat(64'hF2, 8'hFF, 1'b1, 20, acc);
    idle(2);
    csr_read(5, exp_err1, "error_count_nonlast");
    send_beat(64'hF3, 8'h05, 1'b1, 20, acc);
    send_beat(64'hF4, 8'h07, 1'b1, 20, acc);
    idle(2);
    csr_read(5, exp_err2, "error_count_last");
    csr_read(2, 32'd4, "beat_count_4");

    // Reset mid-packet flushes the pipeline register.
    tready_fixed = 1'b0;
    send_beat(64'h99, 8'hFF, 1'b0, 20, acc);
    check("pending_before_reset", 128'(exp_q.size()), 128'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("flush_tvalid", 128'(c2h_tvalid), 128'(0));
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tready_fixed = 1'b1;
    csr_read(1, 32'h0, "status_after_reset");
    csr_read(2, 32'h0, "beat_count_after_reset");
    csr_read(0, 32'h0, "control_after_reset");
    idle(3);
    check("c2h_no_leftover", 128'(exp_q.size()), 128'(0));
    check("csr_no_leftover", 128'(csr_exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
